// File: rtl/inst_fetch_mem.sv
// Instruction fetch memory: one-deep registered response with valid/ready handshake, fault and flush.
// Build option IMEM_LOAD_EN enables program-load writes; without it the load ports are ignored and the array is a fixed ROM.
module inst_fetch_mem #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 64,
  parameter int                ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h0000_0013)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_fault,
  input  logic                     flush,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [DATA_W-1:0]        load_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic              rsp_fault_q, rsp_fault_d;

  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_word;
  logic              addr_oor;
  logic              addr_fault;
  logic              accept;

  assign rd_idx = req_addr[IDX_W+1:2];

  // Any set bit above the word-index field puts the address at or beyond 4*DEPTH.
  if (ADDR_W > IDX_W + 2) begin : g_oor
    assign addr_oor = |req_addr[ADDR_W-1:IDX_W+2];
  end else begin : g_no_oor
    assign addr_oor = 1'b0;
  end

  assign addr_fault = (req_addr[1:0] != 2'b00) || addr_oor;

`ifdef IMEM_LOAD_EN
  logic [DATA_W-1:0] mem_q [DEPTH];

  // No reset on the array: program contents survive rst_n, and loads are gated while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && load_we) mem_q[load_idx] <= load_data;
  end

  // Read samples the pre-edge array, so a same-cycle load to this word returns the old value.
  assign rd_word = mem_q[rd_idx];
`else
  localparam logic [DATA_W-1:0] ROM_BASE = DATA_W'(32'hC000_0000);

  function automatic logic [DATA_W-1:0] rom_word(input logic [IDX_W-1:0] i);
    return ROM_BASE | DATA_W'(i);
  endfunction

  assign rd_word = rom_word(rd_idx);

  logic unused_load;
  assign unused_load = ^{load_we, load_idx, load_data};
`endif

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept    = req_valid && req_ready && !flush;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_fault_d = addr_fault;
      rsp_data_d  = addr_fault ? NOP_WORD : rd_word;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= NOP_WORD;
      rsp_fault_q <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Scoreboard bench for inst_fetch_mem: driver pushes expected responses, a negedge monitor pops and compares.
// Expected words follow the IMEM_LOAD_EN build choice (loaded values vs. fixed ROM pattern).
module tb_inst_fetch_mem;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_fault;
  logic        flush;
  logic        load_we;
  logic [5:0]  load_idx;
  logic [31:0] load_data;

  inst_fetch_mem dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .flush(flush), .load_we(load_we), .load_idx(load_idx), .load_data(load_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   xfer_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   stalls = 0;

`ifdef IMEM_LOAD_EN
  function automatic logic [31:0] word_at(input int i);
    return 32'hA0 + i;
  endfunction
  localparam logic [31:0] OLD5 = 32'h0000_0055;
  localparam logic [31:0] NEW5 = 32'h0000_BEEF;
`else
  function automatic logic [31:0] word_at(input int i);
    return 32'hC000_0000 + i;
  endfunction
  localparam logic [31:0] OLD5 = 32'hC000_0005;
  localparam logic [31:0] NEW5 = 32'hC000_0005;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a transfer happens at the next edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      exp_t e;
      checks++;
      xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got data=%h fault=%b with no response outstanding", rsp_data, rsp_fault);
      end else begin
        e = exp_q.pop_front();
        if (rsp_data !== e.data || rsp_fault !== e.fault) begin
          errors++;
          $display("FAIL rsp: got data=%h fault=%b expected data=%h fault=%b",
                   rsp_data, rsp_fault, e.data, e.fault);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic f);
    int w = 0;
    req_valid = 1'b1;
    req_addr  = a;
    while (!req_ready && w < 20) begin
      tick();
      w++;
    end
    stalls += w;
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    exp_q.push_back('{data: d, fault: f});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic load(input logic [5:0] idx, input logic [31:0] d);
    load_we = 1'b1; load_idx = idx; load_data = d;
    tick();
    load_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    flush = 1'b0; load_we = 1'b0; load_idx = '0; load_data = '0;
    tick();
    tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, NOP);
    chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // First cycle after release: misaligned and out-of-range faults.
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    send(32'h6, NOP, 1'b1);
    send(32'h100, NOP, 1'b1);
    tick();

`ifdef IMEM_LOAD_EN
    for (int i = 0; i < 4; i++) load(6'(i), 32'hA0 + i);
    load(6'd5, OLD5);
`endif

    // Back-to-back stream with rsp_ready held high.
    stalls = 0;
    for (int i = 0; i < 4; i++) send(32'(4 * i), word_at(i), 1'b0);
    tick();
    chk("stream_stalls", 32'(stalls), 32'd0);
    chk("stream_consecutive", 32'(xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[xfer_cyc.size()-4]), 32'd3);

    // Backpressure: response to address 8 held for 3 cycles.
    rsp_ready = 1'b0;
    send(32'h8, word_at(2), 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_data", rsp_data, word_at(2));
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("stall_release_empty", 32'(exp_q.size()), 32'd0);

    // Flush with a held response and a pending request.
    rsp_ready = 1'b0;
    send(32'h4, word_at(1), 1'b0);
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'hC;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("flush_held_count", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    rsp_ready = 1'b1;
    // Flush with an idle output register must still block the request.
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    tick(); tick();
    chk("flush_no_return", 32'(rsp_valid), 32'd0);

    // Same-cycle load and read of word 5.
    load_we = 1'b1; load_idx = 6'd5; load_data = 32'h0000_BEEF;
    send(32'd20, OLD5, 1'b0);
    load_we = 1'b0;
    send(32'd20, NEW5, 1'b0);
    tick();

    // Reset while a response is stalled; load attempted under reset.
    rsp_ready = 1'b0;
    send(32'h0, word_at(0), 1'b0);
    rst_n = 1'b0;
    load_we = 1'b1; load_idx = 6'd0; load_data = 32'hDEAD;
    tick();
    load_we = 1'b0;
    exp_q.delete();
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_data", rsp_data, NOP);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    send(32'h0, word_at(0), 1'b0);
    tick(); tick();
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("end_rsp_valid", 32'(rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/inst_fetch_mem.md
INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, number of words (power of two, 4..4096).
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width of the fetch request.
REQ-004 SHALL have parameter NOP_WORD, default 32'h00000013, word returned on fault or flush.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-007 SHALL have port req_valid, input, 1, fetch request present.
REQ-008 SHALL have port req_ready, output, 1, block accepts a request this cycle.
REQ-009 SHALL have port req_addr, input, ADDR_W, byte address of the fetch.
REQ-010 SHALL have port rsp_valid, output, 1, response held in the output register.
REQ-011 SHALL have port rsp_ready, input, 1, consumer takes the response.
REQ-012 SHALL have port rsp_data, output, DATA_W, fetched instruction word.
REQ-013 SHALL have port rsp_fault, output, 1, request was misaligned or out of range.
REQ-014 SHALL have port flush, input, 1, discard held and accepted responses (branch redirect).
REQ-015 SHALL have port load_we, input, 1, program-load write strobe.
REQ-016 SHALL have port load_idx, input, clog2(DEPTH), word index for the load write.
REQ-017 SHALL have port load_data, input, DATA_W, word to write.

Function
REQ-018 SHALL compute the word index as req_addr[clog2(DEPTH)+1:2].
REQ-019 SHALL accept a request when req_valid && req_ready && !flush.
REQ-020 SHALL drive req_ready = !rsp_valid || rsp_ready, combinationally.
REQ-021 SHALL present the response for an accepted request on the next clock edge: rsp_valid=1, with rsp_data and rsp_fault registered.
REQ-022 SHALL hold rsp_valid, rsp_data and rsp_fault stable while rsp_valid && !rsp_ready && !flush.
REQ-023 SHALL clear rsp_valid when rsp_ready is high and no new request is accepted in the same cycle.
REQ-024 SHALL sustain back-to-back throughput of 1 word/cycle when rsp_ready is held high.
REQ-025 SHALL set rsp_fault=1 and rsp_data=NOP_WORD when req_addr[1:0]!=0 or req_addr>=4*DEPTH; otherwise rsp_fault=0 and rsp_data=mem[index].
REQ-026 SHALL, on flush=1, clear rsp_valid on the next edge and accept no request in that cycle; flush dominates rsp_ready and req_valid.
REQ-027 SHALL not initialise memory contents on reset; contents persist across reset.
REQ-028 SHALL, when a load write and an accepted read target the same word in the same cycle, return the old word (read-before-write); the new word is visible from the following cycle.

Reset
REQ-029 SHALL, while rst_n=0 at a clock edge, set rsp_valid=0, rsp_data=NOP_WORD and rsp_fault=0, and accept no request.
REQ-030 SHALL discard any held response when reset is asserted mid-stall; no stale response is presented after reset release.
REQ-031 SHALL ignore load_we while rst_n=0.
REQ-032 SHALL accept a request in the first cycle after rst_n returns to 1.

Configuration
REQ-033 SHALL, with IMEM_LOAD_EN defined, write load_data to mem[load_idx] on each clock edge where load_we=1 (subject to REQ-031).
REQ-034 SHALL, with IMEM_LOAD_EN undefined, keep the load ports present but ignore them, so the memory behaves as a ROM whose contents are fixed at elaboration.

Verification
REQ-035 SHALL check: after reset, rsp_valid=0, rsp_data=0x00000013, rsp_fault=0, req_ready=1.
REQ-036 SHALL check (IMEM_LOAD_EN defined): load words 0..3 with 0xA0..0xA3; streaming requests to addresses 0,4,8,12 with rsp_ready=1 give rsp_data 0xA0..0xA3 on 4 consecutive cycles.
REQ-037 SHALL check: a request to 0x6 or to 0x100 (DEPTH=64) gives rsp_fault=1 and rsp_data=0x00000013.
REQ-038 SHALL check: rsp_ready=0 for 3 cycles after a response to address 8 keeps rsp_data=mem[2] and holds req_ready=0; rsp_ready=1 then completes the transfer.
REQ-039 SHALL check: flush=1 with req_valid=1 and a response held gives rsp_valid=0 on the next cycle, and the flushed request is never returned.
REQ-040 SHALL check: load_we to index 5 with value 0xBEEF in the same cycle as a read of address 20 returns the old word, and the next read of address 20 returns 0xBEEF.
